// File: rtl/regfile_wb_arbiter_pkg.sv
// regfile_wb_arbiter_pkg
//   Shared constants for the integer register-file write-back path:
//   register index / data widths, the zero register and zero data,
//   and the project-wide number of write-back requesters.
//   Also provides a helper that turns a register index into a one-hot
//   scoreboard mask.
package regfile_wb_arbiter_pkg;

  localparam int RegAddrBits = 5;
  localparam int DataBusBits = 32;
  localparam int NumRegs     = 32;
  localparam int NumWbReq    = 3;

  localparam logic [RegAddrBits-1:0] RegZero  = 5'd0;
  localparam logic [DataBusBits-1:0] DataZero = 32'h0000_0000;

  // One-hot scoreboard mask for register r.
  function automatic logic [NumRegs-1:0] reg_onehot(input logic [RegAddrBits-1:0] r);
    return {{(NumRegs-1){1'b0}}, 1'b1} << r;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if
//   Bundles the write-back requester handshake, the issue-stage
//   allocation port, the scoreboard view and the register-file write port.
//   Modports:
//     slave  : the arbiter (consumes requests/issue, drives grants and rf port)
//     master : the environment (execution units, issue stage, register file)
interface regfile_wb_arbiter_if
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int NUM_REQ = NumWbReq,
  parameter int ADDR_W  = RegAddrBits,
  parameter int DATA_W  = DataBusBits
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      issue_valid;
  logic [ADDR_W-1:0]         issue_rd;
  logic                      issue_ready;
  logic [NumRegs-1:0]        busy;
  logic                      rf_we;
  logic [ADDR_W-1:0]         rf_waddr;
  logic [DATA_W-1:0]         rf_wdata;

  modport slave (
    input  req_valid, req_addr, req_data, issue_valid, issue_rd,
    output req_ready, issue_ready, busy, rf_we, rf_waddr, rf_wdata
  );

  modport master (
    output req_valid, req_addr, req_data, issue_valid, issue_rd,
    input  req_ready, issue_ready, busy, rf_we, rf_waddr, rf_wdata
  );
endinterface

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// rr_arbiter
//   Combinational round-robin arbiter. The search starts at last+1
//   (mod N) and picks the first requester with req set.
//   Ports:
//     req   in  N   request vector
//     last  in  IW  index of the previous winner
//     grant out N   one-hot grant (all zero when no request)
//     idx   out IW  encoded index of the granted requester
module rr_arbiter #(
  parameter int N  = 3,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);

  // Rotating priority search: first valid requester after last wins.
  always_comb begin
    int   cand;
    logic found;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int off = 1; off <= N; off++) begin
      cand = (int'(last) + off) % N;
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = IW'(cand);
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Shares the register file's single write port among NUM_REQ
//   write-back producers with round-robin arbitration and one registered
//   output stage, and keeps a 32-bit scoreboard of registers with an
//   outstanding write so issue can stall on RAW/WAW hazards.
//   Ports:
//     clk    in  rising-edge clock
//     reset  in  asynchronous active-low reset
//     bus    slave modport: req_valid/addr/data/ready, issue_valid/rd/ready,
//            busy, rf_we/rf_waddr/rf_wdata
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int NUM_REQ = NumWbReq,
  parameter int ADDR_W  = RegAddrBits,
  parameter int DATA_W  = DataBusBits
) (
  input  logic                 clk,
  input  logic                 reset,
  regfile_wb_arbiter_if.slave  bus
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [IW-1:0]      last_grant;
  logic [IW-1:0]      grant_idx;
  logic [NUM_REQ-1:0] grant;
  logic               transfer;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_data;
  logic               rf_we_q;
  logic [ADDR_W-1:0]  rf_waddr_q;
  logic [DATA_W-1:0]  rf_wdata_q;
  logic [NumRegs-1:0] busy_q;
  logic [NumRegs-1:0] busy_next;
  logic               issue_ok;

  rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_arb (
    .req   (bus.req_valid),
    .last  (last_grant),
    .grant (grant),
    .idx   (grant_idx)
  );

  assign transfer        = |(bus.req_valid & grant);
  assign bus.req_ready   = grant;
  assign issue_ok        = ~busy_q[bus.issue_rd];
  assign bus.issue_ready = issue_ok;
  assign bus.busy        = busy_q;
  assign bus.rf_we       = rf_we_q;
  assign bus.rf_waddr    = rf_waddr_q;
  assign bus.rf_wdata    = rf_wdata_q;

  // Select the granted requester's destination and data.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_addr = bus.req_addr[i*ADDR_W +: ADDR_W];
        sel_data = bus.req_data[i*DATA_W +: DATA_W];
      end else begin
        sel_addr = sel_addr;
      end
    end
  end

  // Scoreboard update: clear on commit, then set on issue so a same-edge
  // set wins; x0 is never tracked.
  always_comb begin
    busy_next = busy_q;
    if (rf_we_q) begin
      busy_next = busy_next & ~reg_onehot(rf_waddr_q);
    end else begin
      busy_next = busy_next;
    end
    if (bus.issue_valid && issue_ok && (bus.issue_rd != RegZero)) begin
      busy_next = busy_next | reg_onehot(bus.issue_rd);
    end else begin
      busy_next = busy_next;
    end
    busy_next[0] = 1'b0;
  end

  // Output stage, round-robin pointer and scoreboard register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= RegZero;
      rf_wdata_q <= DataZero;
      last_grant <= IW'(NUM_REQ - 1);
      busy_q     <= '0;
    end else begin
      if (transfer) begin
        // A write-back to x0 is consumed but never reaches the register file.
        rf_we_q    <= (sel_addr != RegZero);
        rf_waddr_q <= sel_addr;
        rf_wdata_q <= sel_data;
        last_grant <= grant_idx;
      end else begin
        rf_we_q    <= 1'b0;
      end
      busy_q <= busy_next;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter
//   Directed self-checking bench for regfile_wb_arbiter with NUM_REQ=3.
module tb_regfile_wb_arbiter;
  import regfile_wb_arbiter_pkg::*;

  localparam int NR = 3;
  localparam int AW = 5;
  localparam int DW = 32;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  regfile_wb_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) bus ();

  regfile_wb_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [4:0] a, input logic [31:0] d);
    bus.req_addr[i*AW +: AW] = a;
    bus.req_data[i*DW +: DW] = d;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b0;
    bus.req_valid   = 3'b000;
    bus.req_addr    = '0;
    bus.req_data    = '0;
    bus.issue_valid = 1'b0;
    bus.issue_rd    = 5'd0;
    tick();
    tick();

    // Reset state
    check("rst_we", {31'd0, bus.rf_we}, 32'd0);
    check("rst_waddr", {27'd0, bus.rf_waddr}, 32'd0);
    check("rst_wdata", bus.rf_wdata, 32'd0);
    check("rst_busy", bus.busy, 32'd0);
    check("rst_issue_ready", {31'd0, bus.issue_ready}, 32'd1);
    reset = 1'b1;

    // Single request from requester 1
    set_req(1, 5'd5, 32'h0000_ABCD);
    bus.req_valid = 3'b010;
    #1;
    check("t1_ready", {29'd0, bus.req_ready}, 32'h2);
    tick();
    bus.req_valid = 3'b000;
    check("t1_we", {31'd0, bus.rf_we}, 32'd1);
    check("t1_waddr", {27'd0, bus.rf_waddr}, 32'd5);
    check("t1_wdata", bus.rf_wdata, 32'h0000_ABCD);
    tick();
    check("t1_we_off", {31'd0, bus.rf_we}, 32'd0);
    check("t1_waddr_hold", {27'd0, bus.rf_waddr}, 32'd5);

    // Re-reset so requester 0 wins first, then all three valid
    #2;
    reset = 1'b0;
    #2;
    reset = 1'b1;
    set_req(0, 5'd1, 32'h11);
    set_req(1, 5'd2, 32'h22);
    set_req(2, 5'd3, 32'h33);
    bus.req_valid = 3'b111;
    for (int i = 0; i < 6; i++) begin
      #1;
      check($sformatf("t2_ready_%0d", i), {29'd0, bus.req_ready}, 32'd1 << (i % 3));
      tick();
      check($sformatf("t2_waddr_%0d", i), {27'd0, bus.rf_waddr}, 32'((i % 3) + 1));
      check($sformatf("t2_wdata_%0d", i), bus.rf_wdata, 32'h11 * 32'((i % 3) + 1));
    end
    bus.req_valid = 3'b000;
    tick();

    // Issue r7, second issue blocked, later write-back clears it
    bus.issue_valid = 1'b1;
    bus.issue_rd    = 5'd7;
    #1;
    check("t3_ready_first", {31'd0, bus.issue_ready}, 32'd1);
    tick();
    check("t3_busy_set", bus.busy, 32'h0000_0080);
    check("t3_ready_blocked", {31'd0, bus.issue_ready}, 32'd0);
    tick();
    bus.issue_valid = 1'b0;
    check("t3_busy_hold", bus.busy, 32'h0000_0080);
    tick();
    tick();
    set_req(0, 5'd7, 32'h77);
    bus.req_valid = 3'b001;
    #1;
    check("t3_wb_ready", {29'd0, bus.req_ready}, 32'h1);
    tick();
    bus.req_valid = 3'b000;
    check("t3_we", {31'd0, bus.rf_we}, 32'd1);
    check("t3_busy_pre_commit", bus.busy, 32'h0000_0080);
    tick();
    check("t3_busy_cleared", bus.busy, 32'h0);
    check("t3_we_off", {31'd0, bus.rf_we}, 32'd0);

    // Request to x0 from requester 1
    set_req(1, 5'd0, 32'h0000_FFFF);
    bus.req_valid = 3'b010;
    #1;
    check("t4_ready", {29'd0, bus.req_ready}, 32'h2);
    tick();
    bus.req_valid = 3'b000;
    check("t4_we", {31'd0, bus.rf_we}, 32'd0);
    check("t4_busy", bus.busy, 32'h0);
    // Pointer now at 1: with 0 and 1 valid, 0 must win
    bus.req_valid = 3'b011;
    #1;
    check("t4_ptr_adv", {29'd0, bus.req_ready}, 32'h1);
    bus.req_valid = 3'b000;

    // Commit of r9 and issue of r9 on the same edge
    set_req(0, 5'd9, 32'h99);
    bus.req_valid = 3'b001;
    tick();
    bus.req_valid   = 3'b000;
    bus.issue_valid = 1'b1;
    bus.issue_rd    = 5'd9;
    #1;
    check("t5_we", {31'd0, bus.rf_we}, 32'd1);
    check("t5_issue_ready", {31'd0, bus.issue_ready}, 32'd1);
    tick();
    check("t5_busy9", bus.busy, 32'h0000_0200);

    // Fill busy to 0x0F00, then reset with rf_we=1
    bus.issue_rd = 5'd8;
    tick();
    bus.issue_rd = 5'd10;
    tick();
    bus.issue_rd = 5'd11;
    tick();
    bus.issue_valid = 1'b0;
    set_req(1, 5'd12, 32'hC0C0);
    bus.req_valid = 3'b010;
    tick();
    bus.req_valid = 3'b000;
    check("t6_we_pre", {31'd0, bus.rf_we}, 32'd1);
    check("t6_busy_pre", bus.busy, 32'h0000_0F00);
    #2;
    reset = 1'b0;
    #1;
    check("t6_we_rst", {31'd0, bus.rf_we}, 32'd0);
    check("t6_waddr_rst", {27'd0, bus.rf_waddr}, 32'd0);
    check("t6_wdata_rst", bus.rf_wdata, 32'd0);
    check("t6_busy_rst", bus.busy, 32'd0);
    check("t6_ready_rst", {29'd0, bus.req_ready}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter and register scoreboard for the integer register file. It shares the register file's single write port among NUM_REQ producers (ALU write-back, load unit, multi-cycle mul/div) using round-robin valid/ready arbitration and one registered output stage. It also tracks which architectural registers have an outstanding write, so issue logic can stall on RAW/WAW hazards. It sits between the execution units and the register file `we`/`writeRegister`/`writeData` port.

## Interface
- NUM_REQ, 3, number of write-back requesters (2..8)
- ADDR_W, `RegAddrBits` (5), register index width
- DATA_W, `DataBusBits`, write data width
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- req_valid  in  NUM_REQ  requester i holds a write-back
- req_addr  in  NUM_REQ*ADDR_W  destination of requester i, packed with i at LSBs
- req_data  in  NUM_REQ*DATA_W  data of requester i, packed likewise
- req_ready  out  NUM_REQ  one-hot grant; transfer when valid & ready
- issue_valid  in  1  issue stage allocates destination issue_rd
- issue_rd  in  ADDR_W  destination being allocated
- issue_ready  out  1  allocation allowed this cycle
- busy  out  32  bit r=1 means a write to r is outstanding
- rf_we  out  1  to register file `we`
- rf_waddr  out  ADDR_W  to `writeRegister`
- rf_wdata  out  DATA_W  to `writeData`

## Operation
- Arbitration: round-robin over requesters with req_valid=1. The search starts at last_grant+1 (mod NUM_REQ). At most one req_ready is high per cycle, and it is high only for a valid requester. req_ready is combinational from req_valid and depends on it; requesters must hold valid, addr and data stable until the transfer.
- The last_grant pointer updates only on a transfer. Its reset value is NUM_REQ-1, so requester 0 wins first.
- Output stage: on a transfer, the next edge loads rf_waddr and rf_wdata, and rf_we is set to (addr != `RegZero`). With no transfer, rf_we=0 at the next edge and rf_waddr/rf_wdata hold their values. The stage never back-pressures, so grants are issued every cycle.
- A request to x0 is accepted and consumed but produces no write and does not touch the scoreboard.
- Scoreboard: 32-bit register `busy`. Bit 0 is constantly 0.
  - issue_ready = !busy[issue_rd]. This forbids WAW allocation.
  - When issue_valid & issue_ready & issue_rd != 0, busy[issue_rd] is set at the edge.
  - busy[rf_waddr] is cleared at the edge on which rf_we=1, which is the register-file commit edge.
  - If set and clear hit the same bit at the same edge, set wins.
- A write-back to a register that is not busy is legal. It writes normally, and the clear is a no-op.
- The block does no data forwarding. Consumers must stall while busy is set.

## Timing
- Reset (reset=0, asynchronous): rf_we=0, rf_waddr=0, rf_wdata=0, busy=0, last_grant=NUM_REQ-1. req_ready and issue_ready follow from these values (issue_ready=1). Reset asserted mid-operation drops the in-flight write and clears every busy bit immediately.
- Transfer at edge k: rf_we=1 during cycle k..k+1, and the register file commits at edge k+1. busy for that register reads 0 from cycle k+1 onward, in the same cycle the new value is readable.
- Issue at edge e: busy reads 1 from cycle e onward, and issue_ready for that register is 0.
- Throughput: one write-back per cycle sustained. Worst-case wait for a continuously valid requester is NUM_REQ-1 cycles.

## Structure
- `RegAddrBits`, `DataBusBits`, `RegZero` and `DataZero` come from the shared `diagv2_const.vh`. Add `NumWbReq` there as the project-wide NUM_REQ value.
- Sub-module `rr_arbiter` (parameter N; inputs req and last-grant pointer; output one-hot grant plus encoded index). It is combinational and reusable for the future memory-port arbiter.
- The top level holds the output register, the pointer register and the scoreboard.

## Test plan
- Reset, then req 1 alone with addr=5 and data=0xABCD: req_ready=3'b010 in the same cycle; rf_we=1, rf_waddr=5, rf_wdata=0xABCD for exactly one cycle; then rf_we=0.
- All three requesters valid continuously (addrs 1, 2, 3): grant order 0,1,2,0,1,2 on consecutive edges, and rf_waddr sequence 1,2,3,1,...
- Issue rd=7, then a write-back to 7 after 4 cycles: busy[7]=1 from the issue edge until the commit edge, then 0. A second issue of 7 while busy sees issue_ready=0.
- Request to x0 with data 0xFFFF: req_ready asserted, rf_we stays 0, busy unchanged, and the pointer advances.
- Commit of r9 and issue of r9 on the same edge: busy[9]=1 after the edge.
- Assert reset while rf_we=1 and busy=0x0000_0F00: all outputs are 0 immediately, with no clock edge needed, and busy=0.
